// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq: sequential multiply/divide issue unit for the EX stage.
//
// One request is accepted at a time.
// - Multiplies use the external combinational multiplier. Its operands are
//   registered here, and the low half of the product is captured one cycle
//   after acceptance.
// - Divides and remainders run on an internal restoring divider that
//   produces one quotient bit per cycle, MSB first.
// - Results leave through a valid/ready response port.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid, req_ready  request handshake (req_ready = unit idle)
//   op                    000 MUL, 100 DIV, 101 DIVU, 110 REM, 111 REMU,
//                         other codes complete like MUL with result 0
//   opr0, opr1            multiplicand/dividend, multiplier/divisor
//   flush                 abort current operation, drop pending response
//   mul_opr0, mul_opr1    registered operands to the multiplier
//   mul_result            multiplier product (mod 2^XLEN)
//   resp_valid, resp_ready, result   response handshake and data
module ex_muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] opr0,
  input  logic [XLEN-1:0] opr1,
  input  logic            flush,
  output logic [XLEN-1:0] mul_opr0,
  output logic [XLEN-1:0] mul_opr1,
  input  logic [XLEN-1:0] mul_result,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [2:0]        op_r;
  logic [XLEN-1:0]   mul_opr0_r, mul_opr1_r, result_r;
  logic              resp_valid_r;
  // quo_r starts as the dividend magnitude and shifts into the quotient
  logic [XLEN-1:0]   quo_r, dvs_r, rem_r;
  logic [4:0]        cnt_r;
  logic              neg_q_r, neg_r_r, dz_r, ovf_r;

  logic [XLEN:0]     rem_shift_s, rem_diff_s;
  logic              q_bit_s;
  logic [XLEN-1:0]   rem_step_s, quo_step_s, quo_fix_s, rem_fix_s;
  logic [XLEN-1:0]   div_res_s, spec_res_s, dvd_raw_s;
  logic              acc_sgn_s;

  assign req_ready  = (state_r == ST_IDLE);
  assign resp_valid = resp_valid_r;
  assign result     = result_r;
  assign mul_opr0   = mul_opr0_r;
  assign mul_opr1   = mul_opr1_r;
  // DIV and REM (op[0]==0) are the signed divide flavours
  assign acc_sgn_s  = ~op[0];

  // One restoring-division step plus sign fix-up and special-case results
  always_comb begin
    rem_shift_s = {rem_r, quo_r[XLEN-1]};
    rem_diff_s  = rem_shift_s - {1'b0, dvs_r};
    q_bit_s     = ~rem_diff_s[XLEN];
    if (q_bit_s) begin
      rem_step_s = rem_diff_s[XLEN-1:0];
    end else begin
      rem_step_s = rem_shift_s[XLEN-1:0];
    end
    quo_step_s = {quo_r[XLEN-2:0], q_bit_s};
    quo_fix_s  = neg_q_r ? -quo_step_s : quo_step_s;
    rem_fix_s  = neg_r_r ? -rem_step_s : rem_step_s;
    div_res_s  = op_r[1] ? rem_fix_s : quo_fix_s;
    // quo_r still holds the dividend magnitude at the first DIV cycle
    dvd_raw_s  = neg_r_r ? -quo_r : quo_r;
    if (dz_r) begin
      spec_res_s = op_r[1] ? dvd_raw_s : {XLEN{1'b1}};
    end else begin
      spec_res_s = op_r[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; flush overrides every other transition
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          state_s = op[2] ? ST_DIV : ST_MUL;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MUL: state_s = ST_DONE;
      ST_DIV: begin
        if (dz_r || ovf_r || (cnt_r == 5'd31)) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DIV;
        end
      end
      ST_DONE: begin
        if (resp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
    if (flush) begin
      state_s = ST_IDLE;
    end else begin
      state_s = state_s;
    end
  end

  // Operand capture, divider iteration, result and response-valid registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r         <= 3'd0;
      mul_opr0_r   <= {XLEN{1'b0}};
      mul_opr1_r   <= {XLEN{1'b0}};
      result_r     <= {XLEN{1'b0}};
      resp_valid_r <= 1'b0;
      quo_r        <= {XLEN{1'b0}};
      dvs_r        <= {XLEN{1'b0}};
      rem_r        <= {XLEN{1'b0}};
      cnt_r        <= 5'd0;
      neg_q_r      <= 1'b0;
      neg_r_r      <= 1'b0;
      dz_r         <= 1'b0;
      ovf_r        <= 1'b0;
    end else if (flush) begin
      resp_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            op_r <= op;
            if (op[2]) begin
              quo_r   <= (acc_sgn_s && opr0[XLEN-1]) ? -opr0 : opr0;
              dvs_r   <= (acc_sgn_s && opr1[XLEN-1]) ? -opr1 : opr1;
              rem_r   <= {XLEN{1'b0}};
              cnt_r   <= 5'd0;
              neg_q_r <= acc_sgn_s && (opr0[XLEN-1] ^ opr1[XLEN-1]);
              neg_r_r <= acc_sgn_s && opr0[XLEN-1];
              dz_r    <= (opr1 == {XLEN{1'b0}});
              ovf_r   <= acc_sgn_s && (opr0 == {1'b1, {(XLEN-1){1'b0}}})
                                   && (opr1 == {XLEN{1'b1}});
            end else begin
              mul_opr0_r <= opr0;
              mul_opr1_r <= opr1;
            end
          end
        end
        ST_MUL: begin
          result_r     <= (op_r == 3'b000) ? mul_result : {XLEN{1'b0}};
          resp_valid_r <= 1'b1;
        end
        ST_DIV: begin
          if (dz_r || ovf_r) begin
            result_r     <= spec_res_s;
            resp_valid_r <= 1'b1;
          end else begin
            rem_r <= rem_step_s;
            quo_r <= quo_step_s;
            cnt_r <= cnt_r + 5'd1;
            if (cnt_r == 5'd31) begin
              result_r     <= div_res_s;
              resp_valid_r <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (resp_ready) begin
            resp_valid_r <= 1'b0;
          end
        end
        default: resp_valid_r <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
module tb_ex_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, flush, resp_valid, resp_ready;
  logic [2:0]  op;
  logic [31:0] opr0, opr1, mul_opr0, mul_opr1, mul_result, result;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  // behavioural stand-in for the external combinational multiplier
  assign mul_result = mul_opr0 * mul_opr1;

  ex_muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .op(op), .opr0(opr0), .opr1(opr1), .flush(flush),
    .mul_opr0(mul_opr0), .mul_opr1(mul_opr1), .mul_result(mul_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .result(result)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, " resp_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, " result"}, result, 32'd0);
    chk({tag, " mul_opr0"}, mul_opr0, 32'd0);
    chk({tag, " mul_opr1"}, mul_opr1, 32'd0);
  endtask

  // Reference model: architectural result of a request
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic ovf;
    sa = a;
    sb = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'b000: return a * b;
      3'b100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        else if (ovf) return 32'h8000_0000;
        else return sa / sb;
      end
      3'b101: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        else return a / b;
      end
      3'b110: begin
        if (b == 32'd0) return a;
        else if (ovf) return 32'd0;
        else return sa % sb;
      end
      3'b111: begin
        if (b == 32'd0) return a;
        else return a % b;
      end
      default: return 32'd0;
    endcase
  endfunction

  // Reference model: cycles from accept edge to resp_valid
  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (!o[2]) return 1;
    if (b == 32'd0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 32;
  endfunction

  // Issue one request at a negedge, check latency/busy/result, then hand it off
  task automatic do_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat, input int hold);
    int cnt;
    logic busy_bad;
    chk({nm, " ready before"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; op = o; opr0 = a; opr1 = b; resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; opr0 = $urandom; opr1 = $urandom;
    cnt = 0;
    busy_bad = 1'b0;
    while (resp_valid !== 1'b1 && cnt < 40) begin
      if (req_ready !== 1'b0) busy_bad = 1'b1;
      @(negedge clk);
      cnt++;
    end
    chk({nm, " latency"}, cnt, lat);
    chk({nm, " busy ready low"}, {31'd0, busy_bad}, 32'd0);
    chk({nm, " result"}, result, exp);
    if (!o[2]) begin
      chk({nm, " mul_opr0"}, mul_opr0, a);
      chk({nm, " mul_opr1"}, mul_opr1, b);
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({nm, " hold valid"}, {31'd0, resp_valid}, 32'd1);
      chk({nm, " hold result"}, result, exp);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({nm, " valid dropped"}, {31'd0, resp_valid}, 32'd0);
    chk({nm, " ready after"}, {31'd0, req_ready}, 32'd1);
  endtask

  logic [2:0] op_list [8];
  logic [2:0] ro;
  logic [31:0] ra, rb;
  logic seen;

  initial begin
    vecs[0]  = '{3'b000, 32'd7,          32'd6,          32'd42,         1,  0};
    vecs[1]  = '{3'b000, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  1,  0};
    vecs[2]  = '{3'b101, 32'd100,        32'd7,          32'd14,         32, 5};
    vecs[3]  = '{3'b111, 32'd100,        32'd7,          32'd2,          32, 0};
    vecs[4]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32, 0};
    vecs[5]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32, 0};
    vecs[6]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  0};
    vecs[7]  = '{3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF,  1,  0};
    vecs[8]  = '{3'b110, 32'd5,          32'd0,          32'd5,          1,  0};
    vecs[9]  = '{3'b011, 32'd9,          32'd9,          32'd0,          1,  0};
    vecs[10] = '{3'b000, 32'd3,          32'd5,          32'd15,         1,  5};
    op_list = '{3'b000, 3'b010, 3'b100, 3'b101, 3'b110, 3'b111, 3'b100, 3'b110};

    rst_n = 1'b1; req_valid = 1'b0; op = 3'd0; opr0 = 32'd0; opr1 = 32'd0;
    flush = 1'b0; resp_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk_reset("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++)
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].hold);

    for (int i = 0; i < 24; i++) begin
      ro = op_list[$urandom_range(0, 7)];
      ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = $urandom_range(1, 15);
        3: rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      do_op($sformatf("rnd%0d op%b", i, ro), ro, ra, rb, ref_res(ro, ra, rb), ref_lat(ro, ra, rb), 0);
    end

    // flush during iteration 10 of a DIVU
    req_valid = 1'b1; op = 3'b101; opr0 = 32'd1000; opr1 = 32'd3;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush ready", {31'd0, req_ready}, 32'd1);
    chk("flush valid", {31'd0, resp_valid}, 32'd0);
    seen = 1'b0;
    repeat (35) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) seen = 1'b1;
    end
    chk("flush no response", {31'd0, seen}, 32'd0);
    do_op("post-flush mul", 3'b000, 32'd3, 32'd3, 32'd9, 1, 0);

    // flush wins over the response handshake
    req_valid = 1'b1; op = 3'b000; opr0 = 32'd4; opr1 = 32'd4;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("pre-flush done valid", {31'd0, resp_valid}, 32'd1);
    flush = 1'b1; resp_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; resp_ready = 1'b0;
    chk("flush in done valid", {31'd0, resp_valid}, 32'd0);
    chk("flush in done ready", {31'd0, req_ready}, 32'd1);

    // reset mid-divide
    req_valid = 1'b1; op = 3'b101; opr0 = 32'hFFFF_FFFF; opr1 = 32'd3;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid-div busy", {31'd0, req_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1 chk_reset("mid reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op("post-reset div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
